counter_bank: RTL and testbench
===============================

// Module: counter_bank
//
// PURPOSE
//   Bank of NCH independent up/down counters that supersedes the single
//   clear/increment counter. Each channel adds decrement, parallel load,
//   wrap or saturate mode, sticky overflow/underflow flags and a zero flag.
//   Used by test benches and small DUTs for event, credit and occupancy counting.
//
// PARAMETERS
//   WIDTH     8   counter width per channel (>=2)
//   NCH       4   number of channels (>=1)
//   SATURATE  0   0: wrap on overflow/underflow; 1: clamp at max/0
//
// PORTS
//   aclk      in   1            clock, all logic on rising edge
//   arstn     in   1            asynchronous active-low reset
//   clr       in   NCH          per-channel synchronous clear of count and flags
//   load      in   NCH          per-channel load of load_val slice
//   load_val  in   NCH*WIDTH    load values; channel i = [i*WIDTH +: WIDTH]
//   inc       in   NCH          per-channel +1 request
//   dec       in   NCH          per-channel -1 request
//   flag_clr  in   NCH          per-channel clear of ovf/udf (sticky flags)
//   cnt       out  NCH*WIDTH    registered counts, same slicing as load_val
//   ovf       out  NCH          sticky: an increment occurred at max count
//   udf       out  NCH          sticky: a decrement occurred at zero
//   zero      out  NCH          cnt slice == 0, decoded from registered count
//
// BEHAVIOUR
//   - Reset (arstn=0, async): every cnt slice = 0, ovf = 0, udf = 0; zero = all 1s.
//   - Channels are fully independent; all per-channel rules below apply per slice.
//   - Per-cycle priority: clr > load > (inc xor dec) > hold.
//     clr: cnt<=0, ovf<=0, udf<=0. load: cnt<=load_val, flags unchanged.
//     inc&dec together: net zero, cnt holds, no flag set.
//   - Count latency: 1 cycle (request at edge N, new cnt visible after edge N).
//   - inc when cnt==2^WIDTH-1: SATURATE=0 -> cnt<=0; SATURATE=1 -> cnt holds.
//     ovf<=1 in both modes.
//   - dec when cnt==0: SATURATE=0 -> cnt<=2^WIDTH-1; SATURATE=1 -> cnt holds.
//     udf<=1 in both modes.
//   - Flag set and flag_clr in the same cycle: set wins (flag stays 1).
//   - flag_clr never alters cnt. clr overrides any flag set in that cycle.
//   - zero is combinational from the cnt register only; no input-to-output paths.
//   - Reset asserted mid-operation: outputs go to reset values immediately.
//     After release, the first edge behaves as a normal cycle.
//   - All arithmetic is unsigned, modulo 2^WIDTH; no carry out beyond ovf/udf.
//
// STRUCTURE
//   - counter_pkg.vh: mode localparams (MODE_WRAP=0, MODE_SAT=1), and the
//     CNT_MAX(width) and slice-index helper macros.
//   - Sub-module counter_channel (WIDTH, SATURATE): one counter plus its flags.
//     Instantiated NCH times in a generate loop.
//   - counter_bank contains only the generate loop and port slicing; no shared state.
//
// TESTING  (WIDTH=8, NCH=4; run with both SATURATE=0 and SATURATE=1)
//   1. Reset, then inc on ch0 for 5 cycles -> cnt[0]=5. Other channels stay 0,
//      zero=4'b1110.
//   2. load ch1 with 8'hFE, then inc x2:
//      SATURATE=0 -> cnt[1]=8'h00, ovf[1]=1.
//      SATURATE=1 -> cnt[1]=8'hFF, ovf[1]=1.
//   3. dec on ch2 at 0:
//      SATURATE=0 -> cnt[2]=8'hFF, udf[2]=1.
//      SATURATE=1 -> cnt[2]=0, udf[2]=1.
//      Then flag_clr[2] -> udf[2]=0, cnt unchanged.
//   4. Same cycle on ch3 with clr, load=8'h40 and inc all asserted -> cnt[3]=0.
//      Next cycle load=8'h40 with inc asserted -> cnt[3]=8'h40.
//      Next cycle inc and dec both asserted -> cnt[3] holds 8'h40.
//   5. With cnt[0]=8'hFF, assert inc and flag_clr together -> ovf[0]=1 (set wins).
//   6. Pull arstn low mid-count (cnt[0]=8'h23, ovf[0]=1), asynchronous to aclk
//      -> all outputs reset without a clock edge. After release, inc gives cnt[0]=1.

Source files
------------

// File: rtl/counter_bank_pkg.sv
// Shared definitions for the counter bank: overflow mode selectors and the
// per-cycle action decode that every channel uses to resolve its requests.
package counter_bank_pkg;

  // Overflow/underflow handling modes for the SATURATE parameter
  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // The single action a channel takes on a given clock edge
  typedef enum logic [2:0] {
    ACT_HOLD,
    ACT_CLR,
    ACT_LOAD,
    ACT_INC,
    ACT_DEC
  } act_e;

  // Resolves the request lines into one action.
  // Priority is clr, then load, then a lone inc or dec.
  // inc and dec together cancel out and behave as a hold.
  function automatic act_e decode_action(input logic clr,
                                         input logic load,
                                         input logic inc,
                                         input logic dec);
    act_e act;
    act = ACT_HOLD;
    if (clr) begin
      act = ACT_CLR;
    end else if (load) begin
      act = ACT_LOAD;
    end else if (inc && !dec) begin
      act = ACT_INC;
    end else if (dec && !inc) begin
      act = ACT_DEC;
    end
    return act;
  endfunction

endpackage

// File: rtl/counter_bank_channel.sv
// One up/down counter with parallel load, wrap or saturate handling at the
// ends of the range, sticky overflow/underflow flags and a zero decode.
module counter_bank_channel
  import counter_bank_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int SATURATE = MODE_WRAP
) (
  input  logic             aclk,
  input  logic             arstn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             inc,
  input  logic             dec,
  input  logic             flag_clr,
  output logic [WIDTH-1:0] cnt,
  output logic             ovf,
  output logic             udf,
  output logic             zero
);

  localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic             SAT_MODE = (SATURATE == MODE_SAT);

  act_e             act;
  logic [WIDTH-1:0] cnt_nxt;
  logic             ovf_nxt;
  logic             udf_nxt;

  // Next count and flags; a flag set in this cycle overrides flag_clr,
  // while clr wipes everything including any flag set in the same cycle
  always_comb begin
    act     = decode_action(clr, load, inc, dec);
    cnt_nxt = cnt;
    ovf_nxt = ovf & ~flag_clr;
    udf_nxt = udf & ~flag_clr;
    unique case (act)
      ACT_CLR: begin
        cnt_nxt = CNT_ZERO;
        ovf_nxt = 1'b0;
        udf_nxt = 1'b0;
      end
      ACT_LOAD: begin
        cnt_nxt = load_val;
      end
      ACT_INC: begin
        if (cnt == CNT_MAX) begin
          ovf_nxt = 1'b1;
          cnt_nxt = SAT_MODE ? CNT_MAX : CNT_ZERO;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      ACT_DEC: begin
        if (cnt == CNT_ZERO) begin
          udf_nxt = 1'b1;
          cnt_nxt = SAT_MODE ? CNT_ZERO : CNT_MAX;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      default: begin
        cnt_nxt = cnt;
      end
    endcase
  end

  // Count and flag registers with asynchronous reset to an empty counter
  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      cnt <= CNT_ZERO;
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      ovf <= ovf_nxt;
      udf <= udf_nxt;
    end
  end

  assign zero = (cnt == CNT_ZERO);

endmodule

// File: rtl/counter_bank.sv
// Bank of NCH independent counters. This level only slices the packed
// buses and replicates the channel; there is no state shared between channels.
module counter_bank
  import counter_bank_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int NCH      = 4,
  parameter int SATURATE = MODE_WRAP
) (
  input  logic                 aclk,
  input  logic                 arstn,
  input  logic [NCH-1:0]       clr,
  input  logic [NCH-1:0]       load,
  input  logic [NCH*WIDTH-1:0] load_val,
  input  logic [NCH-1:0]       inc,
  input  logic [NCH-1:0]       dec,
  input  logic [NCH-1:0]       flag_clr,
  output logic [NCH*WIDTH-1:0] cnt,
  output logic [NCH-1:0]       ovf,
  output logic [NCH-1:0]       udf,
  output logic [NCH-1:0]       zero
);

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    counter_bank_channel #(
      .WIDTH    (WIDTH),
      .SATURATE (SATURATE)
    ) u_ch (
      .aclk     (aclk),
      .arstn    (arstn),
      .clr      (clr[g]),
      .load     (load[g]),
      .load_val (load_val[g*WIDTH +: WIDTH]),
      .inc      (inc[g]),
      .dec      (dec[g]),
      .flag_clr (flag_clr[g]),
      .cnt      (cnt[g*WIDTH +: WIDTH]),
      .ovf      (ovf[g]),
      .udf      (udf[g]),
      .zero     (zero[g])
    );
  end

endmodule

// File: tb/tb_counter_bank.sv
// Self-checking bench for counter_bank: directed scenarios followed by a
// random phase, all compared against an arithmetic model of each counter.
module tb_counter_bank;

  parameter int SAT = 0;

  localparam int WIDTH = 8;
  localparam int NCH   = 4;
  localparam int MAXV  = (1 << WIDTH) - 1;

  logic                 aclk = 1'b0;
  logic                 arstn = 1'b0;
  logic [NCH-1:0]       clr = '0;
  logic [NCH-1:0]       load = '0;
  logic [NCH*WIDTH-1:0] load_val = '0;
  logic [NCH-1:0]       inc = '0;
  logic [NCH-1:0]       dec = '0;
  logic [NCH-1:0]       flag_clr = '0;
  logic [NCH*WIDTH-1:0] cnt;
  logic [NCH-1:0]       ovf;
  logic [NCH-1:0]       udf;
  logic [NCH-1:0]       zero;

  int total = 0;
  int bad   = 0;

  int mcnt [NCH];
  bit movf [NCH];
  bit mudf [NCH];

  // Free-running clock, 10 time units per period
  always #5 aclk = ~aclk;

  counter_bank #(
    .WIDTH    (WIDTH),
    .NCH      (NCH),
    .SATURATE (SAT)
  ) dut (
    .aclk     (aclk),
    .arstn    (arstn),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
    .inc      (inc),
    .dec      (dec),
    .flag_clr (flag_clr),
    .cnt      (cnt),
    .ovf      (ovf),
    .udf      (udf),
    .zero     (zero)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp)
      else begin
        bad++;
        $error("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
  endtask

  function automatic logic [31:0] chCnt(input int ch);
    return 32'(cnt[ch*WIDTH +: WIDTH]);
  endfunction

  task automatic resetModel();
    for (int i = 0; i < NCH; i++) begin
      mcnt[i] = 0;
      movf[i] = 1'b0;
      mudf[i] = 1'b0;
    end
  endtask

  task automatic idle();
    clr      = '0;
    load     = '0;
    load_val = '0;
    inc      = '0;
    dec      = '0;
    flag_clr = '0;
  endtask

  // Counter behaviour expressed as integer arithmetic over [0, MAXV]
  task automatic stepModel(input int i);
    int nv;
    if (clr[i]) begin
      mcnt[i] = 0;
      movf[i] = 1'b0;
      mudf[i] = 1'b0;
    end else begin
      if (flag_clr[i]) begin
        movf[i] = 1'b0;
        mudf[i] = 1'b0;
      end
      if (load[i]) begin
        mcnt[i] = int'(load_val[i*WIDTH +: WIDTH]);
      end else if (inc[i] != dec[i]) begin
        nv = inc[i] ? mcnt[i] + 1 : mcnt[i] - 1;
        if (nv > MAXV) begin
          movf[i] = 1'b1;
          nv = (SAT != 0) ? MAXV : nv - (MAXV + 1);
        end else if (nv < 0) begin
          mudf[i] = 1'b1;
          nv = (SAT != 0) ? 0 : nv + (MAXV + 1);
        end
        mcnt[i] = nv;
      end
    end
  endtask

  // Advance the model with the current inputs, then clock the DUT once
  task automatic applyStimulus();
    for (int i = 0; i < NCH; i++) stepModel(i);
    @(posedge aclk);
    #1;
  endtask

  task automatic checkOutput(input string tag);
    for (int i = 0; i < NCH; i++) begin
      check($sformatf("%s_cnt%0d", tag, i), chCnt(i), 32'(mcnt[i]));
      check($sformatf("%s_ovf%0d", tag, i), 32'(ovf[i]), 32'(movf[i]));
      check($sformatf("%s_udf%0d", tag, i), 32'(udf[i]), 32'(mudf[i]));
      check($sformatf("%s_zero%0d", tag, i), 32'(zero[i]), 32'(mcnt[i] == 0));
    end
  endtask

  initial begin
    $display("[TB] start, SATURATE=%0d", SAT);
    resetModel();
    idle();
    #12;
    checkOutput("reset");
    check("reset_zero", 32'(zero), 32'hF);
    #1 arstn = 1'b1;

    // 1: five increments on ch0
    for (int k = 0; k < 5; k++) begin
      idle();
      inc[0] = 1'b1;
      applyStimulus();
    end
    idle();
    check("t1_cnt0", chCnt(0), 32'd5);
    check("t1_zero", 32'(zero), 32'b1110);
    checkOutput("t1");

    // 2: load ch1 near the top, then step over it
    load[1] = 1'b1;
    load_val[1*WIDTH +: WIDTH] = 8'hFE;
    applyStimulus();
    idle();
    inc[1] = 1'b1;
    applyStimulus();
    applyStimulus();
    idle();
    check("t2_cnt1", chCnt(1), (SAT != 0) ? 32'hFF : 32'h00);
    check("t2_ovf1", 32'(ovf[1]), 32'd1);
    checkOutput("t2");

    // 3: decrement ch2 at zero, then clear its flags
    dec[2] = 1'b1;
    applyStimulus();
    idle();
    check("t3_cnt2", chCnt(2), (SAT != 0) ? 32'h00 : 32'hFF);
    check("t3_udf2", 32'(udf[2]), 32'd1);
    flag_clr[2] = 1'b1;
    applyStimulus();
    idle();
    check("t3_udf2_clr", 32'(udf[2]), 32'd0);
    check("t3_cnt2_keep", chCnt(2), (SAT != 0) ? 32'h00 : 32'hFF);
    checkOutput("t3");

    // 4: priority on ch3
    clr[3] = 1'b1;
    load[3] = 1'b1;
    inc[3] = 1'b1;
    load_val[3*WIDTH +: WIDTH] = 8'h40;
    applyStimulus();
    check("t4_clr", chCnt(3), 32'h00);
    clr[3] = 1'b0;
    applyStimulus();
    check("t4_load", chCnt(3), 32'h40);
    idle();
    inc[3] = 1'b1;
    dec[3] = 1'b1;
    applyStimulus();
    idle();
    check("t4_hold", chCnt(3), 32'h40);
    checkOutput("t4");

    // 5: overflow set and flag_clr in the same cycle on ch0
    load[0] = 1'b1;
    load_val[0 +: WIDTH] = 8'hFF;
    applyStimulus();
    idle();
    inc[0] = 1'b1;
    flag_clr[0] = 1'b1;
    applyStimulus();
    idle();
    check("t5_ovf0", 32'(ovf[0]), 32'd1);
    checkOutput("t5");

    // 6: asynchronous reset in the middle of a cycle
    load[0] = 1'b1;
    load_val[0 +: WIDTH] = 8'h23;
    applyStimulus();
    idle();
    check("t6_pre_cnt0", chCnt(0), 32'h23);
    check("t6_pre_ovf0", 32'(ovf[0]), 32'd1);
    #2 arstn = 1'b0;
    #1;
    resetModel();
    check("t6_rst_cnt", 32'(cnt), 32'h0);
    check("t6_rst_ovf", 32'(ovf), 32'h0);
    check("t6_rst_udf", 32'(udf), 32'h0);
    check("t6_rst_zero", 32'(zero), 32'hF);
    #1 arstn = 1'b1;
    inc[0] = 1'b1;
    applyStimulus();
    idle();
    check("t6_post_cnt0", chCnt(0), 32'd1);
    checkOutput("t6");

    // Random traffic, with clear and load kept rare so counts can reach the ends
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < NCH; i++) begin
        clr[i]      = ($urandom_range(0, 31) == 0);
        load[i]     = ($urandom_range(0, 15) == 0);
        inc[i]      = ($urandom_range(0, 2) != 0) ^ (i[0]);
        dec[i]      = ($urandom_range(0, 2) == 0) ^ (i[0]);
        flag_clr[i] = ($urandom_range(0, 7) == 0);
        load_val[i*WIDTH +: WIDTH] = ($urandom_range(0, 3) == 0) ? 8'hFF - 8'($urandom_range(0, 2))
                                                                   : 8'($urandom_range(0, 3));
      end
      applyStimulus();
      checkOutput("rand");
    end
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
